timer_bank_n: RTL and testbench

- Parametrised successor to the fixed 3-channel counter peripheral.
- Provides NCH independent WIDTH-bit down-counters.
- Each channel has a selectable mode (stop / one-shot / periodic / square-wave), per-channel tick sources, interrupt pending/mask and a single bus write port.
- Sits behind the MIO bus decoder, fed by clock-divider bits; its output and irq drive the CPU INT line and GPIO.

---
 rtl/timer_bank_n_if.sv | 14 +
 rtl/timer_bank_n.sv | 169 ++++++++++++++++
 tb/tb_timer_bank_n.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_n_if.sv
// Bus port of timer_bank_n: one write port plus a combinational count read-back.
interface timer_bank_n_if #(
    parameter int WIDTH = 32,
    parameter int CHW   = 3
);
    logic             we;
    logic [CHW-1:0]   sel;
    logic [WIDTH-1:0] wdata;
    logic [CHW-1:0]   rd_sel;
    logic [WIDTH-1:0] cnt_out;

    modport master (output we, sel, wdata, rd_sel, input cnt_out);
    modport slave  (input we, sel, wdata, rd_sel, output cnt_out);
endinterface

// File: rtl/timer_bank_n.sv
// NCH-channel down-counter bank (stop / one-shot / periodic / square) with irq pending/mask.
// Optional atomic count snapshot on sel=NCH+2 is enabled by defining TIMER_SNAPSHOT_EN.
module timer_bank_n #(
    parameter int NCH   = 3,
    parameter int WIDTH = 32,
    parameter int CHW   = 3
) (
    input  logic           clk,
    input  logic           RSTN,
    input  logic [NCH-1:0] tick,
    timer_bank_n_if.slave  bus,
    output logic [NCH-1:0] ch_out,
    output logic           irq
);
    // sel must be able to address NCH loads plus control, W1C and snapshot
    if ((NCH < 1) || (NCH > 8) || (WIDTH < 8) || (WIDTH > 32) || ((1 << CHW) < NCH + 3)) begin : g_param_check
        $error("timer_bank_n: illegal NCH/WIDTH/CHW combination");
    end

    localparam logic [CHW-1:0] SEL_CTRL = CHW'(NCH);
    localparam logic [CHW-1:0] SEL_CLR  = CHW'(NCH + 1);

    logic                 ctrl_we;
    logic                 clr_we;
    logic [NCH*WIDTH-1:0] view_flat;
    logic [NCH-1:0]       pend_vec;
    logic [NCH-1:0]       ien_vec;

    assign ctrl_we = bus.we && (bus.sel == SEL_CTRL);
    assign clr_we  = bus.we && (bus.sel == SEL_CLR);

`ifdef TIMER_SNAPSHOT_EN
    localparam logic [CHW-1:0] SEL_SNAP = CHW'(NCH + 2);
    logic snap_we;
    assign snap_we = bus.we && (bus.sel == SEL_SNAP);
`endif

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_reg, cnt_next;
        logic [WIDTH-1:0] load_reg, load_next;
        logic [1:0]       mode_reg, mode_next, mode_wr;
        logic             ien_reg, ien_next, ien_wr;
        logic             pend_reg, pend_next;
        logic             out_reg, out_next;
        logic             tick_d_reg;
        logic             edge_hit;
        logic             term;
        logic             load_we;

        // Control-word fields that fall outside a narrow wdata read as zero
        if (2 * gi + 1 < WIDTH) begin : g_mode_field
            assign mode_wr = bus.wdata[2*gi+1 : 2*gi];
        end else begin : g_mode_none
            assign mode_wr = 2'b00;
        end
        if (16 + gi < WIDTH) begin : g_ien_field
            assign ien_wr = bus.wdata[16+gi];
        end else begin : g_ien_none
            assign ien_wr = 1'b0;
        end

        assign edge_hit = tick[gi] & ~tick_d_reg;
        assign load_we  = bus.we && (bus.sel == CHW'(gi));

        always_comb begin
            cnt_next  = cnt_reg;
            load_next = load_reg;
            mode_next = mode_reg;
            ien_next  = ien_reg;
            out_next  = out_reg;
            term      = 1'b0;

            // Periodic output is a single-clock pulse
            if (mode_reg == 2'b10) begin
                out_next = 1'b0;
            end

            if (edge_hit && (mode_reg != 2'b00)) begin
                if (cnt_reg > WIDTH'(1)) begin
                    cnt_next = cnt_reg - WIDTH'(1);
                end else if (cnt_reg == WIDTH'(1)) begin
                    term = 1'b1;
                    case (mode_reg)
                        2'b01: begin
                            cnt_next = '0;
                            out_next = 1'b1;
                        end
                        2'b10: begin
                            cnt_next = load_reg;
                            out_next = 1'b1;
                        end
                        default: begin
                            cnt_next = load_reg;
                            out_next = ~out_reg;
                        end
                    endcase
                end
            end

            // A load write swallows any edge arriving in the same cycle
            if (load_we) begin
                cnt_next  = bus.wdata;
                load_next = bus.wdata;
                out_next  = 1'b0;
                term      = 1'b0;
            end

            if (ctrl_we) begin
                mode_next = mode_wr;
                ien_next  = ien_wr;
                if (mode_wr != mode_reg) begin
                    out_next = 1'b0;
                end
            end

            pend_next = (pend_reg & ~(clr_we & bus.wdata[gi])) | term;
        end

        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                cnt_reg    <= '0;
                load_reg   <= '0;
                mode_reg   <= 2'b00;
                ien_reg    <= 1'b0;
                pend_reg   <= 1'b0;
                out_reg    <= 1'b0;
                tick_d_reg <= 1'b0;
            end else begin
                cnt_reg    <= cnt_next;
                load_reg   <= load_next;
                mode_reg   <= mode_next;
                ien_reg    <= ien_next;
                pend_reg   <= pend_next;
                out_reg    <= out_next;
                tick_d_reg <= tick[gi];
            end
        end

`ifdef TIMER_SNAPSHOT_EN
        logic [WIDTH-1:0] snap_reg;
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                snap_reg <= '0;
            end else if (snap_we) begin
                snap_reg <= cnt_reg;
            end
        end
        assign view_flat[gi*WIDTH +: WIDTH] = snap_reg;
`else
        assign view_flat[gi*WIDTH +: WIDTH] = cnt_reg;
`endif

        assign ch_out[gi]   = out_reg;
        assign pend_vec[gi] = pend_reg;
        assign ien_vec[gi]  = ien_reg;
    end

    always_comb begin
        bus.cnt_out = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.rd_sel == CHW'(k)) begin
                bus.cnt_out = view_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    assign irq = |(pend_vec & ien_vec);
endmodule

// File: tb/tb_timer_bank_n.sv
// Directed bench for timer_bank_n: one-shot, periodic, square, collisions, snapshot, async reset.
module tb_timer_bank_n;
    localparam int NCH   = 3;
    localparam int WIDTH = 32;
    localparam int CHW   = 3;

    logic           clk = 1'b0;
    logic           RSTN;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] ch_out;
    logic           irq;
    int             total = 0;
    int             bad   = 0;

    timer_bank_n_if #(.WIDTH(WIDTH), .CHW(CHW)) bus ();

    timer_bank_n #(.NCH(NCH), .WIDTH(WIDTH), .CHW(CHW)) dut (
        .clk    (clk),
        .RSTN   (RSTN),
        .tick   (tick),
        .bus    (bus),
        .ch_out (ch_out),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [CHW-1:0] s, input logic [WIDTH-1:0] d);
        bus.we    = 1'b1;
        bus.sel   = s;
        bus.wdata = d;
        step();
        bus.we    = 1'b0;
        $display("write sel=%0d wdata=0x%0h cnt_out=0x%0h ch_out=%b irq=%b", s, d, bus.cnt_out, ch_out, irq);
    endtask

    // In snapshot builds cnt_out shows the snapshot, so take one before reading
    task automatic cnt_chk(input string tag, input logic [31:0] exp);
`ifdef TIMER_SNAPSHOT_EN
        wr(CHW'(NCH + 2), '0);
`endif
        check(tag, bus.cnt_out, exp);
    endtask

    task automatic rise(input int k);
        tick[k] = 1'b1;
        step();
    endtask

    task automatic fall(input int k);
        tick[k] = 1'b0;
        step();
    endtask

    initial begin
        RSTN       = 1'b0;
        tick       = '0;
        bus.we     = 1'b0;
        bus.sel    = '0;
        bus.wdata  = '0;
        bus.rd_sel = '0;
        #12;
        check("rst_cnt", bus.cnt_out, 32'd0);
        check("rst_ch_out", 32'(ch_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        step();
        RSTN = 1'b1;
        step();

        // One-shot on ch0, load 3
        wr(3'd3, 32'h0001_0001);
        wr(3'd0, 32'd3);
        bus.rd_sel = 3'd0;
        cnt_chk("os_load", 32'd3);
        for (int e = 1; e <= 3; e++) begin
            rise(0);
            fall(0);
            cnt_chk($sformatf("os_cnt_e%0d", e), 32'(3 - e));
            if (e == 2) check("os_irq_early", 32'(irq), 32'd0);
        end
        check("os_ch_out", 32'(ch_out[0]), 32'd1);
        check("os_irq", 32'(irq), 32'd1);
        rise(0);
        fall(0);
        cnt_chk("os_idle_cnt", 32'd0);
        wr(3'd4, 32'd1);
        check("os_w1c_irq", 32'(irq), 32'd0);
        check("os_sticky", 32'(ch_out[0]), 32'd1);

        // Periodic on ch1, load 2, irq masked
        wr(3'd3, 32'h0000_0009);
        check("os_keep_out", 32'(ch_out[0]), 32'd1);
        wr(3'd1, 32'd2);
        bus.rd_sel = 3'd1;
        for (int e = 1; e <= 6; e++) begin
            rise(1);
            check($sformatf("per_pulse_e%0d", e), 32'(ch_out[1]), (e % 2 == 0) ? 32'd1 : 32'd0);
            cnt_chk($sformatf("per_cnt_e%0d", e), (e % 2 == 0) ? 32'd2 : 32'd1);
            fall(1);
            check($sformatf("per_low_e%0d", e), 32'(ch_out[1]), 32'd0);
        end
        check("per_masked_irq", 32'(irq), 32'd0);
        wr(3'd3, 32'h0002_0009);
        check("per_unmask_irq", 32'(irq), 32'd1);
        wr(3'd4, 32'd2);
        check("per_w1c_irq", 32'(irq), 32'd0);

        // Square on ch2, load 4, two full periods
        wr(3'd3, 32'h0000_0039);
        wr(3'd2, 32'd4);
        bus.rd_sel = 3'd2;
        for (int e = 1; e <= 16; e++) begin
            rise(2);
            fall(2);
            check($sformatf("sq_out_e%0d", e), 32'(ch_out[2]), ((e / 4) % 2 == 1) ? 32'd1 : 32'd0);
            if (e % 4 == 0 || e % 4 == 3)
                cnt_chk($sformatf("sq_cnt_e%0d", e), (e % 4 == 0) ? 32'd4 : 32'(4 - e % 4));
        end

        // Load write coincident with an edge: write wins, no decrement
        tick[2]   = 1'b1;
        bus.we    = 1'b1;
        bus.sel   = 3'd2;
        bus.wdata = 32'd7;
        step();
        bus.we    = 1'b0;
        fall(2);
        cnt_chk("col_load_edge", 32'd7);

        // W1C coincident with terminal event on ch1: pend stays set
        wr(3'd3, 32'h0002_0039);
        bus.rd_sel = 3'd1;
        rise(1);
        fall(1);
        cnt_chk("col_pre_cnt", 32'd1);
        check("col_pre_irq", 32'(irq), 32'd0);
        tick[1]   = 1'b1;
        bus.we    = 1'b1;
        bus.sel   = 3'd4;
        bus.wdata = 32'd2;
        step();
        bus.we    = 1'b0;
        check("col_w1c_irq", 32'(irq), 32'd1);
        fall(1);
        wr(3'd4, 32'd2);
        check("col_clear_irq", 32'(irq), 32'd0);

        // load = 0 in periodic: channel idle
        wr(3'd1, 32'd0);
        for (int e = 1; e <= 10; e++) begin
            rise(1);
            check($sformatf("zero_out_e%0d", e), 32'(ch_out[1]), 32'd0);
            fall(1);
        end
        cnt_chk("zero_cnt", 32'd0);
        check("zero_irq", 32'(irq), 32'd0);

        // Snapshot write (ignored without the feature)
        wr(3'd3, 32'h0000_003A);
        check("mode_chg_clr", 32'(ch_out[0]), 32'd0);
        wr(3'd0, 32'd5);
        bus.rd_sel = 3'd0;
        rise(0); fall(0);
        rise(0); fall(0);
        wr(3'd5, '0);
        rise(0); fall(0);
`ifdef TIMER_SNAPSHOT_EN
        check("snap_frozen", bus.cnt_out, 32'd3);
`else
        check("snap_live", bus.cnt_out, 32'd2);
`endif
        bus.rd_sel = 3'd3;
        #1;
        check("rd_sel_oob", bus.cnt_out, 32'd0);
        bus.rd_sel = 3'd0;

        // Asynchronous reset in the middle of a periodic pulse
        wr(3'd3, 32'h0001_003A);
        rise(0); fall(0);
        rise(0);
        check("pre_rst_out", 32'(ch_out[0]), 32'd1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_cnt", bus.cnt_out, 32'd0);
        check("arst_ch_out", 32'(ch_out), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        tick = '0;
        step();
        RSTN = 1'b1;
        step();
        wr(3'd0, 32'd5);
        tick = 3'b111;
        step();
        check("post_rst_out", 32'(ch_out), 32'd0);
        tick = '0;
        step();
        cnt_chk("post_rst_stop", 32'd5);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
